// File: rtl/prewish_button_poller.sv
// Periodic poller for prewish_debounce: requests, awaits reply, captures buttons.
// Ports: CLK_I/RST_I clock and sync reset; STB_O/STB_I/DAT_I debouncer link;
//        i_poll_now force poll; o_buttons/o_press/o_release/o_valid/o_timeout.
module prewish_button_poller #(
    parameter int unsigned POLL_PERIOD = 120000,
    parameter int unsigned POLL_BITS   = 17,
    parameter int unsigned STB_LEN     = 2,
    parameter int unsigned TIMEOUT     = 8,
    parameter int unsigned TO_BITS     = 4
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    output logic       STB_O,
    input  logic       STB_I,
    input  logic [7:0] DAT_I,
    input  logic       i_poll_now,
    output logic [7:0] o_buttons,
    output logic [7:0] o_press,
    output logic [7:0] o_release,
    output logic       o_valid,
    output logic       o_timeout
);

    localparam int unsigned SL_BITS = (STB_LEN > 1) ? $clog2(STB_LEN) : 1;

    localparam logic [POLL_BITS-1:0] POLL_RELOAD = POLL_BITS'(POLL_PERIOD - 1);
    localparam logic [SL_BITS-1:0]   STB_LAST    = SL_BITS'(STB_LEN - 1);
    localparam logic [TO_BITS-1:0]   TO_LAST     = TO_BITS'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [POLL_BITS-1:0] poll_cnt;
    logic [POLL_BITS-1:0] poll_nxt;
    logic [SL_BITS-1:0]   stb_cnt;
    logic [SL_BITS-1:0]   stb_nxt;
    logic [TO_BITS-1:0]   to_cnt;
    logic [TO_BITS-1:0]   to_nxt;
    logic                 stb_o_nxt;
    logic [7:0]           buttons_nxt;
    logic [7:0]           press_nxt;
    logic [7:0]           rel_nxt;
    logic                 valid_nxt;
    logic                 timeout_nxt;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state     <= S_IDLE;
            poll_cnt  <= POLL_RELOAD;
            stb_cnt   <= '0;
            to_cnt    <= '0;
            STB_O     <= 1'b0;
            o_buttons <= '0;
            o_press   <= '0;
            o_release <= '0;
            o_valid   <= 1'b0;
            o_timeout <= 1'b0;
        end else begin
            state     <= state_nxt;
            poll_cnt  <= poll_nxt;
            stb_cnt   <= stb_nxt;
            to_cnt    <= to_nxt;
            STB_O     <= stb_o_nxt;
            o_buttons <= buttons_nxt;
            o_press   <= press_nxt;
            o_release <= rel_nxt;
            o_valid   <= valid_nxt;
            o_timeout <= timeout_nxt;
        end
    end

    // STB_O is registered, so it is computed for the cycle after the edge:
    // high on the edge entering REQ and on every REQ edge except the last.
    always_comb begin
        state_nxt   = S_IDLE;
        poll_nxt    = poll_cnt;
        stb_nxt     = stb_cnt;
        to_nxt      = to_cnt;
        stb_o_nxt   = 1'b0;
        buttons_nxt = o_buttons;
        press_nxt   = '0;
        rel_nxt     = '0;
        valid_nxt   = 1'b0;
        timeout_nxt = o_timeout;

        case (state)
            S_IDLE: begin
                // Counter expiry and a forced poll collapse into one request.
                if (poll_cnt == '0 || i_poll_now) begin
                    state_nxt = S_REQ;
                    poll_nxt  = POLL_RELOAD;
                    stb_nxt   = '0;
                    stb_o_nxt = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                    poll_nxt  = poll_cnt - POLL_BITS'(1);
                end
            end

            S_REQ: begin
                if (stb_cnt == STB_LAST) begin
                    state_nxt = S_WAIT;
                    to_nxt    = '0;
                end else begin
                    state_nxt = S_REQ;
                    stb_nxt   = stb_cnt + SL_BITS'(1);
                    stb_o_nxt = 1'b1;
                end
            end

            S_WAIT: begin
                // A reply on the expiry cycle still counts as a reply.
                if (STB_I) begin
                    state_nxt   = S_IDLE;
                    buttons_nxt = DAT_I;
                    press_nxt   = DAT_I & ~o_buttons;
                    rel_nxt     = ~DAT_I & o_buttons;
                    valid_nxt   = 1'b1;
                    timeout_nxt = 1'b0;
                end else if (to_cnt == TO_LAST) begin
                    state_nxt   = S_IDLE;
                    timeout_nxt = 1'b1;
                end else begin
                    state_nxt = S_WAIT;
                    to_nxt    = to_cnt + TO_BITS'(1);
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_prewish_button_poller.sv
// Scoreboard bench for prewish_button_poller with a debouncer reply model.
// Expected captures/timeouts are queued by stimulus and checked by a monitor.
module tb_prewish_button_poller;

    logic       CLK_I = 1'b0;
    logic       RST_I = 1'b1;
    logic       STB_O;
    logic       STB_I = 1'b0;
    logic [7:0] DAT_I = 8'h00;
    logic       i_poll_now = 1'b0;
    logic [7:0] o_buttons;
    logic [7:0] o_press;
    logic [7:0] o_release;
    logic       o_valid;
    logic       o_timeout;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_to;
        logic [7:0] b;
        logic [7:0] p;
        logic [7:0] r;
        logic       to;
    } exp_t;

    exp_t q[$];

    bit         resp_en  = 1'b0;
    logic [7:0] resp_dat = 8'h00;
    int         resp_dly = 2;

    prewish_button_poller #(
        .POLL_PERIOD(20),
        .POLL_BITS  (17),
        .STB_LEN    (2),
        .TIMEOUT    (8),
        .TO_BITS    (4)
    ) dut (
        .CLK_I     (CLK_I),
        .RST_I     (RST_I),
        .STB_O     (STB_O),
        .STB_I     (STB_I),
        .DAT_I     (DAT_I),
        .i_poll_now(i_poll_now),
        .o_buttons (o_buttons),
        .o_press   (o_press),
        .o_release (o_release),
        .o_valid   (o_valid),
        .o_timeout (o_timeout)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push_cap(input logic [7:0] b, input logic [7:0] p,
                            input logic [7:0] r);
        exp_t e;
        e.is_to = 1'b0; e.b = b; e.p = p; e.r = r; e.to = 1'b0;
        q.push_back(e);
    endtask

    task automatic push_to(input logic [7:0] b);
        exp_t e;
        e.is_to = 1'b1; e.b = b; e.p = 8'h00; e.r = 8'h00; e.to = 1'b1;
        q.push_back(e);
    endtask

    // Debouncer model: one-cycle reply resp_dly cycles after STB_O falls.
    initial begin
        forever begin
            @(negedge STB_O);
            if (resp_en) begin
                automatic logic [7:0] d = resp_dat;
                automatic int n = resp_dly;
                repeat (n) @(posedge CLK_I);
                #1;
                STB_I = 1'b1;
                DAT_I = d;
                @(posedge CLK_I);
                #1;
                STB_I = 1'b0;
                DAT_I = 8'h00;
            end
        end
    end

    // Monitor: pops an expectation on every capture or timeout rise.
    initial begin
        logic to_prev;
        to_prev = 1'b0;
        forever begin
            @(negedge CLK_I);
            if (!RST_I && o_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_valid", {24'd0, o_buttons}, 32'hFFFF);
                end else begin
                    automatic exp_t e = q.pop_front();
                    check("kind_valid", {31'd0, e.is_to}, 32'd0);
                    check("cap_buttons", {24'd0, o_buttons}, {24'd0, e.b});
                    check("cap_press", {24'd0, o_press}, {24'd0, e.p});
                    check("cap_release", {24'd0, o_release}, {24'd0, e.r});
                    check("cap_timeout", {31'd0, o_timeout}, {31'd0, e.to});
                end
            end
            if (!RST_I && o_timeout && !to_prev) begin
                if (q.size() == 0) begin
                    check("unexpected_timeout", 32'd1, 32'd0);
                end else begin
                    automatic exp_t e = q.pop_front();
                    check("kind_timeout", {31'd0, e.is_to}, 32'd1);
                    check("to_buttons", {24'd0, o_buttons}, {24'd0, e.b});
                end
            end
            if (!o_valid && (o_press != 8'h00 || o_release != 8'h00))
                check("edge_no_valid", {16'd0, o_press, o_release}, 32'd0);
            to_prev = o_timeout;
        end
    end

    task automatic wait_stb(output int n);
        n = 0;
        do begin
            @(posedge CLK_I);
            #1;
            n++;
        end while (!STB_O && n < 200);
        if (!STB_O) check("stb_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge CLK_I);
            #1;
            n++;
        end while (!o_valid && n < 100);
        if (!o_valid) check("valid_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic wait_to(output int n);
        n = 0;
        do begin
            @(posedge CLK_I);
            #1;
            n++;
        end while (!o_timeout && n < 100);
        if (!o_timeout) check("timeout_wait_expired", 32'd0, 32'd1);
    endtask

    initial begin
        int n;
        int hi;
        int vcnt;

        // Reset and check reset state.
        RST_I = 1'b1;
        repeat (2) @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        check("rst_stb", {31'd0, STB_O}, 32'd0);
        check("rst_buttons", {24'd0, o_buttons}, 32'd0);
        check("rst_press", {24'd0, o_press}, 32'd0);
        check("rst_release", {24'd0, o_release}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_timeout", {31'd0, o_timeout}, 32'd0);

        // 1: no responder, first request 20 edges after reset, then timeout.
        push_to(8'h00);
        wait_stb(n);
        check("t1_first_stb", n, 32'd20);
        hi = 0;
        for (int i = 0; i < 4; i++) begin
            if (STB_O) hi++;
            @(posedge CLK_I);
            #1;
        end
        check("t1_stb_len", hi, 32'd2);
        repeat (5) @(posedge CLK_I);
        #1;
        check("t1_to_early", {31'd0, o_timeout}, 32'd0);
        @(posedge CLK_I);
        #1;
        check("t1_to_set", {31'd0, o_timeout}, 32'd1);

        // 2: reply 01 on the next periodic poll.
        resp_en  = 1'b1;
        resp_dly = 2;
        resp_dat = 8'h01;
        push_cap(8'h01, 8'h01, 8'h00);
        wait_stb(n);
        check("t2_next_stb", n, 32'd20);
        wait_valid(n);
        check("t2_latency", n, 32'd5);

        // 3: replies 03 then 02.
        resp_dat = 8'h03;
        push_cap(8'h03, 8'h02, 8'h00);
        wait_stb(n);
        check("t3a_stb", n, 32'd20);
        wait_valid(n);
        resp_dat = 8'h02;
        push_cap(8'h02, 8'h00, 8'h01);
        wait_stb(n);
        wait_valid(n);
        @(posedge CLK_I);
        #1;
        check("t3_hold_buttons", {24'd0, o_buttons}, 32'h02);
        check("t3_valid_pulse", {31'd0, o_valid}, 32'd0);

        // 4: forced poll with counter at 15, then poll_now during WAIT.
        repeat (3) @(posedge CLK_I);
        #1;
        resp_dat = 8'h80;
        push_cap(8'h80, 8'h80, 8'h02);
        i_poll_now = 1'b1;
        @(posedge CLK_I);
        #1;
        i_poll_now = 1'b0;
        check("t4_force_stb", {31'd0, STB_O}, 32'd1);
        repeat (2) @(posedge CLK_I);
        #1;
        check("t4_in_wait", {31'd0, STB_O}, 32'd0);
        i_poll_now = 1'b1;
        @(posedge CLK_I);
        #1;
        i_poll_now = 1'b0;
        wait_valid(n);
        resp_en = 1'b0;
        wait_stb(n);
        check("t4_no_extra_req", n, 32'd20);

        // 5: reset during REQ, then a late reply.
        RST_I = 1'b1;
        @(posedge CLK_I);
        #1;
        RST_I = 1'b0;
        check("t5_stb", {31'd0, STB_O}, 32'd0);
        check("t5_buttons", {24'd0, o_buttons}, 32'd0);
        check("t5_timeout", {31'd0, o_timeout}, 32'd0);
        repeat (2) @(posedge CLK_I);
        #1;
        STB_I = 1'b1;
        DAT_I = 8'hFF;
        @(posedge CLK_I);
        #1;
        STB_I = 1'b0;
        DAT_I = 8'h00;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_valid) vcnt++;
            @(posedge CLK_I);
            #1;
        end
        check("t5_no_valid", vcnt, 32'd0);

        // 6: reply on the last WAIT cycle wins over expiry.
        resp_en  = 1'b1;
        resp_dly = 7;
        resp_dat = 8'h81;
        push_cap(8'h81, 8'h81, 8'h00);
        wait_stb(n);
        check("t6_stb_after_rst", n, 32'd11);
        wait_valid(n);
        check("t6_latency", n, 32'd10);

        // 7: reply one cycle too late is ignored; timeout with buttons kept.
        resp_dly = 8;
        resp_dat = 8'h55;
        push_to(8'h81);
        wait_stb(n);
        wait_to(n);
        check("t7_to_latency", n, 32'd10);
        repeat (5) @(posedge CLK_I);
        #1;
        check("t7_buttons", {24'd0, o_buttons}, 32'h81);
        check("queue_empty", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
